piso_serializer: RTL and testbench

//   Parallel-in/serial-out word serializer; upstream feeder of the 6-bit serial-in shift register.

---
 rtl/piso_serializer.sv | 165 ++++++++++++++++
 tb/tb_piso_serializer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out word serializer. A WIDTH-bit word is accepted
//   through a valid/ready handshake and shifted out MSB-first on o_sout, one bit
//   per clock. The MSB goes first so that a downstream serial-in shift register
//   clocked by the same clock holds the whole word (Q == DIN) on the edge that
//   follows the last bit.
//
//   Optional feature macro: PARITY_EN
//     defined   : one extra cycle after DIN[0] carries the even-parity bit ^DIN
//     undefined : no parity state and no parity logic
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_din          parallel word, sampled only on an accepted load
//   i_load_valid   upstream has a word on i_din
//   o_load_ready   serializer can accept a word this cycle (combinational)
//   o_sout         serial data, IDLE_LEVEL when nothing is being sent
//   o_sout_valid   o_sout carries a data (or parity) bit this cycle
//   o_busy         word in flight
//   o_done         high only while the last data bit is on o_sout
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH      = 6,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  output logic             o_sout,
  output logic             o_sout_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  // Counter value while the second-to-last bit is out; the next bit is the last.
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);

`ifdef PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;     // bits still to send, left-aligned
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_next; // index of the bit currently on o_sout
  logic             r_sout, w_sout_next;
  logic             r_sout_valid, w_sout_valid_next;
  logic             r_done, w_done_next;
`ifdef PARITY_EN
  logic             r_parity, w_parity_next;
`endif

  logic w_last_bit;
  logic w_accept;

  assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == LAST_CNT);

  // Ready in the final cycle of a word too, so back-to-back words have no gap.
`ifdef PARITY_EN
  assign o_load_ready = (r_state == S_IDLE) || (r_state == S_PAR);
`else
  assign o_load_ready = (r_state == S_IDLE) || w_last_bit;
`endif

  assign w_accept = i_load_valid && o_load_ready;

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
`ifdef PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_sout       <= w_sout_next;
      r_sout_valid <= w_sout_valid_next;
      r_done       <= w_done_next;
`ifdef PARITY_EN
      r_parity     <= w_parity_next;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_next      = r_state;
    w_shift_next      = r_shift;
    w_bit_cnt_next    = r_bit_cnt;
    w_sout_next       = r_sout;
    w_sout_valid_next = r_sout_valid;
    w_done_next       = 1'b0;
`ifdef PARITY_EN
    w_parity_next     = r_parity;
`endif

    if (w_accept) begin
      // MSB goes out next cycle; the rest waits left-aligned in the shifter.
      w_state_next      = S_SHIFT;
      w_sout_next       = i_din[WIDTH-1];
      w_shift_next      = {i_din[WIDTH-2:0], 1'b0};
      w_bit_cnt_next    = '0;
      w_sout_valid_next = 1'b1;
`ifdef PARITY_EN
      w_parity_next     = ^i_din;
`endif
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (w_last_bit) begin
`ifdef PARITY_EN
            w_state_next      = S_PAR;
            w_sout_next       = r_parity;
            w_sout_valid_next = 1'b1;
`else
            w_state_next      = S_IDLE;
            w_sout_next       = IDLE_LEVEL;
            w_sout_valid_next = 1'b0;
            w_bit_cnt_next    = '0;
`endif
          end else begin
            w_sout_next    = r_shift[WIDTH-1];
            w_shift_next   = {r_shift[WIDTH-2:0], 1'b0};
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_done_next    = (r_bit_cnt == PRE_LAST);
          end
        end
`ifdef PARITY_EN
        S_PAR: begin
          w_state_next      = S_IDLE;
          w_sout_next       = IDLE_LEVEL;
          w_sout_valid_next = 1'b0;
          w_bit_cnt_next    = '0;
        end
`endif
        default: begin
          w_state_next      = S_IDLE;
          w_sout_next       = IDLE_LEVEL;
          w_sout_valid_next = 1'b0;
          w_bit_cnt_next    = '0;
        end
      endcase
    end
  end

  assign o_sout       = r_sout;
  assign o_sout_valid = r_sout_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Self-checking bench for piso_serializer. Each accepted word pushes its
//   expected {sout, done} sequence onto a scoreboard queue; every cycle the
//   scenario task pops one entry while o_sout_valid is expected and compares.
//   Honours PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int unsigned WIDTH      = 6;
  localparam logic        IDLE_LEVEL = 1'b0;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] i_din;
  logic             i_load_valid;
  logic             o_load_ready;
  logic             o_sout;
  logic             o_sout_valid;
  logic             o_busy;
  logic             o_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0]       sb_q[$];   // {expected sout, expected done}
  logic [WIDTH-1:0] ds_q;      // model of the downstream serial-in register

  piso_serializer #(
    .WIDTH      (WIDTH),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_din        (i_din),
    .i_load_valid (i_load_valid),
    .o_load_ready (o_load_ready),
    .o_sout       (o_sout),
    .o_sout_valid (o_sout_valid),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ds_q <= {ds_q[WIDTH-2:0], o_sout};

  // Drive one cycle of stimulus; if the serializer is expected to be ready
  // (scoreboard drained) a valid word is accepted and its bits are queued.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d);
    i_load_valid = v;
    i_din        = d;
    if (v && sb_q.size() == 0) begin
      $display("[TB] accept word 0x%0h", d);
      for (int i = WIDTH - 1; i >= 0; i--) sb_q.push_back({d[i], (i == 0)});
`ifdef PARITY_EN
      sb_q.push_back({^d, 1'b0});
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; i_load_valid = 1'b0; i_din = '0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_sout, o_sout_valid, o_busy, o_done, o_load_ready} !== {IDLE_LEVEL, 4'b0001}) begin
      tests_failed++;
      $display("FAIL reset_outputs: sout/valid/busy/done/ready=%b required %b",
               {o_sout, o_sout_valid, o_busy, o_done, o_load_ready}, {IDLE_LEVEL, 4'b0001});
    end
    sb_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic       exp_valid;
    logic [1:0] exp;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_valid = (sb_q.size() != 0);
      tests_run++;
      if (o_sout_valid !== exp_valid || o_busy !== exp_valid) begin
        tests_failed++;
        $display("FAIL single_valid c%0d: valid=%b busy=%b required %b", c, o_sout_valid, o_busy, exp_valid);
      end
      exp = exp_valid ? sb_q.pop_front() : {IDLE_LEVEL, 1'b0};
      tests_run++;
      if ({o_sout, o_done} !== exp) begin
        tests_failed++;
        $display("FAIL single_bit c%0d: sout,done=%b required %b", c, {o_sout, o_done}, exp);
      end
      tests_run++;
      if (o_load_ready !== (sb_q.size() == 0)) begin
        tests_failed++;
        $display("FAIL single_ready c%0d: ready=%b required %b", c, o_load_ready, (sb_q.size() == 0));
      end
`ifndef PARITY_EN
      if (c == 7) begin
        tests_run++;
        if (ds_q !== 6'b101101) begin
          tests_failed++;
          $display("FAIL single_downstream: Q=%b required %b", ds_q, 6'b101101);
        end
      end
`endif
      drive(c == 0, (c == 0) ? 6'b101101 : WIDTH'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic             exp_valid;
    logic [1:0]       exp;
    logic [WIDTH-1:0] wq[$];
    logic [11:0]      bits;
    int nvalid, ndone, first_c, last_c;
    logic acc;
    wq = '{6'h2A, 6'h15};
    bits = '0; nvalid = 0; ndone = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_valid = (sb_q.size() != 0);
      tests_run++;
      if (o_sout_valid !== exp_valid || o_busy !== exp_valid) begin
        tests_failed++;
        $display("FAIL b2b_valid c%0d: valid=%b busy=%b required %b", c, o_sout_valid, o_busy, exp_valid);
      end
      exp = exp_valid ? sb_q.pop_front() : {IDLE_LEVEL, 1'b0};
      tests_run++;
      if ({o_sout, o_done} !== exp) begin
        tests_failed++;
        $display("FAIL b2b_bit c%0d: sout,done=%b required %b", c, {o_sout, o_done}, exp);
      end
      tests_run++;
      if (o_load_ready !== (sb_q.size() == 0)) begin
        tests_failed++;
        $display("FAIL b2b_ready c%0d: ready=%b required %b", c, o_load_ready, (sb_q.size() == 0));
      end
      if (o_sout_valid === 1'b1) begin
        bits = {bits[10:0], o_sout};
        nvalid++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (o_done === 1'b1) ndone++;
      acc = (wq.size() != 0) && (sb_q.size() == 0);
      drive(wq.size() != 0, (wq.size() != 0) ? wq[0] : '0);
      if (acc) void'(wq.pop_front());
    end
`ifndef PARITY_EN
    tests_run++;
    if (bits !== 12'b101010010101 || nvalid != 12 || (last_c - first_c) != 11 || ndone != 2) begin
      tests_failed++;
      $display("FAIL b2b_stream: bits=%b valid_cycles=%0d span=%0d done=%0d required %b 12 11 2",
               bits, nvalid, last_c - first_c, ndone, 12'b101010010101);
    end
`endif
  endtask

  task automatic test_busy_ignore();
    logic       exp_valid;
    logic [1:0] exp;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_valid = (sb_q.size() != 0);
      tests_run++;
      if (o_sout_valid !== exp_valid || o_busy !== exp_valid) begin
        tests_failed++;
        $display("FAIL busy_valid c%0d: valid=%b busy=%b required %b", c, o_sout_valid, o_busy, exp_valid);
      end
      exp = exp_valid ? sb_q.pop_front() : {IDLE_LEVEL, 1'b0};
      tests_run++;
      if ({o_sout, o_done} !== exp) begin
        tests_failed++;
        $display("FAIL busy_bit c%0d: sout,done=%b required %b", c, {o_sout, o_done}, exp);
      end
      tests_run++;
      if (o_load_ready !== (sb_q.size() == 0)) begin
        tests_failed++;
        $display("FAIL busy_ready c%0d: ready=%b required %b", c, o_load_ready, (sb_q.size() == 0));
      end
      // cycle 2: word 0x00 offered while busy must be dropped
      drive(c == 0 || c == 2, (c == 0) ? 6'h3F : 6'h00);
    end
  endtask

  task automatic test_reset_mid();
    logic       exp_valid;
    logic [1:0] exp;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      exp_valid = (sb_q.size() != 0);
      tests_run++;
      if (o_sout_valid !== exp_valid || o_busy !== exp_valid) begin
        tests_failed++;
        $display("FAIL rstmid_valid c%0d: valid=%b busy=%b required %b", c, o_sout_valid, o_busy, exp_valid);
      end
      exp = exp_valid ? sb_q.pop_front() : {IDLE_LEVEL, 1'b0};
      tests_run++;
      if ({o_sout, o_done} !== exp) begin
        tests_failed++;
        $display("FAIL rstmid_bit c%0d: sout,done=%b required %b", c, {o_sout, o_done}, exp);
      end
      tests_run++;
      if (o_load_ready !== (sb_q.size() == 0)) begin
        tests_failed++;
        $display("FAIL rstmid_ready c%0d: ready=%b required %b", c, o_load_ready, (sb_q.size() == 0));
      end
      if (c == 3) begin
        // three bits out; pull reset between edges, outputs must clear at once
        drive(1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_sout, o_sout_valid, o_busy, o_done, o_load_ready} !== {IDLE_LEVEL, 4'b0001}) begin
          tests_failed++;
          $display("FAIL rstmid_async: sout/valid/busy/done/ready=%b required %b",
                   {o_sout, o_sout_valid, o_busy, o_done, o_load_ready}, {IDLE_LEVEL, 4'b0001});
        end
        sb_q.delete();
      end else begin
        if (c == 5) rst_n = 1'b1;
        drive(c == 0 || c == 8, (c == 0) ? 6'h2A : 6'h15);
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic             exp_valid;
    logic [1:0]       exp;
    logic [WIDTH-1:0] wq[$];
    logic [13:0]      bits;
    logic             acc;
    wq = '{6'b000111, 6'b000011};
    bits = '0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      exp_valid = (sb_q.size() != 0);
      tests_run++;
      if (o_sout_valid !== exp_valid || o_busy !== exp_valid) begin
        tests_failed++;
        $display("FAIL par_valid c%0d: valid=%b busy=%b required %b", c, o_sout_valid, o_busy, exp_valid);
      end
      exp = exp_valid ? sb_q.pop_front() : {IDLE_LEVEL, 1'b0};
      tests_run++;
      if ({o_sout, o_done} !== exp) begin
        tests_failed++;
        $display("FAIL par_bit c%0d: sout,done=%b required %b", c, {o_sout, o_done}, exp);
      end
      tests_run++;
      if (o_load_ready !== (sb_q.size() == 0)) begin
        tests_failed++;
        $display("FAIL par_ready c%0d: ready=%b required %b", c, o_load_ready, (sb_q.size() == 0));
      end
      if (o_sout_valid === 1'b1) bits = {bits[12:0], o_sout};
      acc = (wq.size() != 0) && (sb_q.size() == 0);
      drive(wq.size() != 0, (wq.size() != 0) ? wq[0] : '0);
      if (acc) void'(wq.pop_front());
    end
    tests_run++;
    if (bits !== 14'b0001111_0000110) begin
      tests_failed++;
      $display("FAIL par_stream: bits=%b required %b", bits, 14'b0001111_0000110);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
